// File: rtl/time_counter_pkg.sv
// Shared digit limits, the packed HH:MM:SS type and the load sanitizer
// used by the timekeeping and time-edit stages.
package time_counter_pkg;

    localparam logic [3:0] SEC0_MAX       = 4'd9;
    localparam logic [3:0] SEC1_MAX       = 4'd5;
    localparam logic [3:0] MIN0_MAX       = 4'd9;
    localparam logic [3:0] MIN1_MAX       = 4'd5;
    localparam logic [3:0] HRS0_MAX       = 4'd9;
    localparam logic [3:0] HRS1_MAX       = 4'd2;
    localparam logic [3:0] HRS0_MAX_AT_20 = 4'd3;

    typedef struct packed {
        logic [3:0] hrs1;
        logic [3:0] hrs0;
        logic [3:0] min1;
        logic [3:0] min0;
        logic [3:0] sec1;
        logic [3:0] sec0;
    } bcd_time_t;

    // Out-of-range digits become 0; 24..29 clamps to 23.
    function automatic bcd_time_t sanitize(input bcd_time_t t);
        bcd_time_t s;
        s = t;
        if (s.sec0 > SEC0_MAX) s.sec0 = '0;
        if (s.sec1 > SEC1_MAX) s.sec1 = '0;
        if (s.min0 > MIN0_MAX) s.min0 = '0;
        if (s.min1 > MIN1_MAX) s.min1 = '0;
        if (s.hrs0 > HRS0_MAX) s.hrs0 = '0;
        if (s.hrs1 > HRS1_MAX) s.hrs1 = '0;
        if (s.hrs1 == HRS1_MAX && s.hrs0 > HRS0_MAX_AT_20)
            s.hrs0 = HRS0_MAX_AT_20;
        return s;
    endfunction

endpackage

// File: rtl/time_counter_if.sv
// Bundle between the time-edit stage (master) and time_counter (slave).
// master drives set_mode/n_*; slave returns digits, sec_tick, day_wrap.
// ALARM_EN adds al_*/alarm_on (master) and alarm (slave).
interface time_counter_if;
    logic       set_mode;
    logic [3:0] n_sec0, n_sec1, n_min0, n_min1, n_hrs0, n_hrs1;
    logic [3:0] sec0, sec1, min0, min1, hrs0, hrs1;
    logic       sec_tick;
    logic       day_wrap;
`ifdef ALARM_EN
    logic [3:0] al_hrs1, al_hrs0, al_min1, al_min0;
    logic       alarm_on;
    logic       alarm;
`endif

    modport master (
        output set_mode, n_sec0, n_sec1, n_min0, n_min1, n_hrs0, n_hrs1,
`ifdef ALARM_EN
        output al_hrs1, al_hrs0, al_min1, al_min0, alarm_on,
        input  alarm,
`endif
        input  sec0, sec1, min0, min1, hrs0, hrs1, sec_tick, day_wrap
    );

    modport slave (
        input  set_mode, n_sec0, n_sec1, n_min0, n_min1, n_hrs0, n_hrs1,
`ifdef ALARM_EN
        input  al_hrs1, al_hrs0, al_min1, al_min0, alarm_on,
        output alarm,
`endif
        output sec0, sec1, min0, min1, hrs0, hrs1, sec_tick, day_wrap
    );
endinterface

// File: rtl/time_counter_bcd_digit.sv
// One BCD digit counting 0..MAX with load and carry-out.
// Ports: clk, rst, load, load_val, inc in; q, carry (inc && q==MAX) out.
module bcd_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       inc,
    output logic [3:0] q,
    output logic       carry
);
    assign carry = inc && (q == MAX);

    always_ff @(posedge clk) begin
        if (rst)       q <= '0;
        else if (load) q <= load_val;
        else if (inc)  q <= carry ? 4'd0 : q + 4'd1;
    end
endmodule

// File: rtl/time_counter.sv
// HH:MM:SS BCD timekeeper with prescaler; loads edited digits in set mode.
// Ports: clk, rst (sync, active-high), tif (time_counter_if.slave).
// Optional macro ALARM_EN adds the HH:MM alarm.
module time_counter
    import time_counter_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int PRE_W  = 27
) (
    input  logic clk,
    input  logic rst,
    time_counter_if.slave tif
);
    localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(CLK_HZ - 1);

    logic [PRE_W-1:0] pre;
    logic             tick;
    bcd_time_t        ld;
    logic [3:0]       s0, s1, m0, m1, hrs0, hrs1;
    logic [3:0]       h0n, h1n;
    logic             c0, c1, c2, c3, hr_wrap;

    // A load in the wrap cycle suppresses the tick.
    assign tick = !tif.set_mode && (pre == PRE_TC);

    assign ld = sanitize({tif.n_hrs1, tif.n_hrs0, tif.n_min1,
                          tif.n_min0, tif.n_sec1, tif.n_sec0});

    always_ff @(posedge clk) begin
        if (rst || tif.set_mode) pre <= '0;
        else if (tick)           pre <= '0;
        else                     pre <= pre + PRE_W'(1);
    end

    bcd_digit #(.MAX(SEC0_MAX)) u_sec0 (
        .clk(clk), .rst(rst), .load(tif.set_mode), .load_val(ld.sec0),
        .inc(tick), .q(s0), .carry(c0));
    bcd_digit #(.MAX(SEC1_MAX)) u_sec1 (
        .clk(clk), .rst(rst), .load(tif.set_mode), .load_val(ld.sec1),
        .inc(c0), .q(s1), .carry(c1));
    bcd_digit #(.MAX(MIN0_MAX)) u_min0 (
        .clk(clk), .rst(rst), .load(tif.set_mode), .load_val(ld.min0),
        .inc(c1), .q(m0), .carry(c2));
    bcd_digit #(.MAX(MIN1_MAX)) u_min1 (
        .clk(clk), .rst(rst), .load(tif.set_mode), .load_val(ld.min1),
        .inc(c2), .q(m1), .carry(c3));

    // Hours pair: ones limit depends on the tens digit, so 23 -> 00.
    assign hr_wrap = c3 && (hrs1 == HRS1_MAX) && (hrs0 == HRS0_MAX_AT_20);

    always_comb begin
        h1n = hrs1;
        h0n = hrs0;
        if (c3) begin
            if (hr_wrap) begin
                h1n = '0;
                h0n = '0;
            end else if (hrs0 == HRS0_MAX) begin
                h1n = hrs1 + 4'd1;
                h0n = '0;
            end else begin
                h0n = hrs0 + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hrs1         <= '0;
            hrs0         <= '0;
            tif.sec_tick <= 1'b0;
            tif.day_wrap <= 1'b0;
        end else if (tif.set_mode) begin
            hrs1         <= ld.hrs1;
            hrs0         <= ld.hrs0;
            tif.sec_tick <= 1'b0;
            tif.day_wrap <= 1'b0;
        end else begin
            hrs1         <= h1n;
            hrs0         <= h0n;
            tif.sec_tick <= tick;
            tif.day_wrap <= hr_wrap;
        end
    end

    assign tif.sec0 = s0;
    assign tif.sec1 = s1;
    assign tif.min0 = m0;
    assign tif.min1 = m1;
    assign tif.hrs0 = hrs0;
    assign tif.hrs1 = hrs1;

`ifdef ALARM_EN
    logic [3:0] m0n, m1n;

    // Minute digits as they will be after this edge.
    assign m0n = c2 ? 4'd0 : (c1 ? m0 + 4'd1 : m0);
    assign m1n = c3 ? 4'd0 : (c2 ? m1 + 4'd1 : m1);

    // Re-evaluated on every minute rollover, so it lasts at most 60 s.
    always_ff @(posedge clk) begin
        if (rst || tif.set_mode || !tif.alarm_on)
            tif.alarm <= 1'b0;
        else if (c1)
            tif.alarm <= ({h1n, h0n, m1n, m0n} ==
                          {tif.al_hrs1, tif.al_hrs0,
                           tif.al_min1, tif.al_min0});
    end
`endif

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench for time_counter with CLK_HZ=4.
// Reference model tracks time as seconds-of-day.
module tb_time_counter;

    localparam int HZ = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    time_counter_if tif ();

    time_counter #(.CLK_HZ(HZ), .PRE_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .tif(tif)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int m_secs = 0;
    int m_cnt  = 0;
    bit m_tick = 0;
    bit m_wrap = 0;
    bit m_alarm = 0;
    int n_val[6];

    function automatic int load_secs(int h1, int h0, int mi1, int mi0,
                                     int s1, int s0);
        if (s0 > 9) s0 = 0;
        if (s1 > 5) s1 = 0;
        if (mi0 > 9) mi0 = 0;
        if (mi1 > 5) mi1 = 0;
        if (h0 > 9) h0 = 0;
        if (h1 > 2) h1 = 0;
        if (h1 == 2 && h0 > 3) h0 = 3;
        return (h1 * 10 + h0) * 3600 + (mi1 * 10 + mi0) * 60 + s1 * 10 + s0;
    endfunction

    function automatic logic [23:0] to_digits(int s);
        int h, mi, x;
        h  = s / 3600;
        mi = (s / 60) % 60;
        x  = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10),
                4'(x / 10), 4'(x % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_n(input int h1, input int h0, input int mi1,
                         input int mi0, input int s1, input int s0);
        n_val = '{h1, h0, mi1, mi0, s1, s0};
        tif.n_hrs1 = 4'(h1);
        tif.n_hrs0 = 4'(h0);
        tif.n_min1 = 4'(mi1);
        tif.n_min0 = 4'(mi0);
        tif.n_sec1 = 4'(s1);
        tif.n_sec0 = 4'(s0);
    endtask

    // One clock: advance the model with the inputs seen at the edge,
    // then compare just after the edge.
    task automatic step();
        @(posedge clk);
        m_tick = 0;
        m_wrap = 0;
        if (rst) begin
            m_secs  = 0;
            m_cnt   = 0;
            m_alarm = 0;
        end else if (tif.set_mode) begin
            m_secs  = load_secs(n_val[0], n_val[1], n_val[2],
                                n_val[3], n_val[4], n_val[5]);
            m_cnt   = 0;
            m_alarm = 0;
        end else begin
            m_cnt++;
            if (m_cnt == HZ) begin
                m_cnt  = 0;
                m_secs = (m_secs + 1) % 86400;
                m_tick = 1;
                m_wrap = (m_secs == 0);
            end
`ifdef ALARM_EN
            if (!tif.alarm_on)
                m_alarm = 0;
            else if (m_tick && m_secs % 60 == 0)
                m_alarm = (m_secs / 60 ==
                           (tif.al_hrs1 * 10 + tif.al_hrs0) * 60 +
                           tif.al_min1 * 10 + tif.al_min0);
`endif
        end
        #1;
        chk("time", {tif.hrs1, tif.hrs0, tif.min1, tif.min0,
                     tif.sec1, tif.sec0}, to_digits(m_secs));
        chk("sec_tick", tif.sec_tick, m_tick);
        chk("day_wrap", tif.day_wrap, m_wrap);
`ifdef ALARM_EN
        chk("alarm", tif.alarm, m_alarm);
`endif
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1;
        tif.set_mode = 1'b0;
        set_n(0, 0, 0, 0, 0, 0);
`ifdef ALARM_EN
        tif.al_hrs1 = 4'd0;
        tif.al_hrs0 = 4'd7;
        tif.al_min1 = 4'd3;
        tif.al_min0 = 4'd0;
        tif.alarm_on = 1'b0;
`endif
        // Reset, then first tick exactly HZ cycles after release
        steps(2);
        chk("reset_digits", {tif.hrs1, tif.hrs0, tif.min1, tif.min0,
                             tif.sec1, tif.sec0}, 24'h0);
        rst = 1'b0;
        steps(3);
        chk("no_early_tick", tif.sec_tick, 1'b0);
        step();
        chk("first_tick", tif.sec_tick, 1'b1);
        chk("first_sec0", tif.sec0, 4'd1);

        // 12:34:58 -> :59 -> 12:35:00
        tif.set_mode = 1'b1;
        set_n(1, 2, 3, 4, 5, 8);
        step();
        tif.set_mode = 1'b0;
        steps(8);
        chk("min_carry", {tif.min1, tif.min0, tif.sec1, tif.sec0},
            16'h3500);

        // Day wrap
        tif.set_mode = 1'b1;
        set_n(2, 3, 5, 9, 5, 9);
        step();
        tif.set_mode = 1'b0;
        steps(4);
        chk("day_wrap_pulse", tif.day_wrap, 1'b1);
        step();
        chk("day_wrap_drop", tif.day_wrap, 1'b0);

        // Sanitizing
        tif.set_mode = 1'b1;
        set_n(2, 9, 7, 3, 4, 12);
        step();
        chk("sanitize", {tif.hrs1, tif.hrs0, tif.min1, tif.sec0},
            16'h2300);
        set_n(1, 4, 2, 2, 3, 3);
        step();

        // Load wins over a coincident prescaler wrap
        tif.set_mode = 1'b0;
        steps(3);
        tif.set_mode = 1'b1;
        set_n(0, 8, 1, 5, 4, 4);
        step();
        chk("load_wins", tif.sec_tick, 1'b0);
        tif.set_mode = 1'b0;
        steps(4);
        chk("tick_after_load", tif.sec_tick, 1'b1);

        // Reset mid-count restarts the full second
        steps(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        steps(4);

`ifdef ALARM_EN
        tif.alarm_on = 1'b1;
        tif.set_mode = 1'b1;
        set_n(0, 7, 2, 9, 5, 9);
        step();
        tif.set_mode = 1'b0;
        steps(4);
        chk("alarm_set", tif.alarm, 1'b1);
        steps(60 * HZ);
        chk("alarm_timeout", tif.alarm, 1'b0);
        tif.set_mode = 1'b1;
        step();
        tif.set_mode = 1'b0;
        steps(8);
        tif.alarm_on = 1'b0;
        step();
        chk("alarm_off", tif.alarm, 1'b0);
        tif.alarm_on = 1'b1;
`endif

        // Randomized loads, runs and resets
        for (int i = 0; i < 60; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end else if (r < 4) begin
                tif.set_mode = 1'b1;
                set_n(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
                steps(int'($urandom_range(1, 3)));
                if (r == 1) set_n(2, 3, 5, 9, 5, int'($urandom_range(6, 9)));
                if (r == 1) step();
                tif.set_mode = 1'b0;
            end
            steps(int'($urandom_range(1, 30)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/time_counter.md
Name: time_counter

Overview:
Timekeeping stage for the digital clock. It holds the running HH:MM:SS time as six BCD digits and advances it once per second, using an internal prescaler from the system clock. Its digit outputs feed the time-edit stage and the display. While set mode is active, it loads the edit stage's n_* digits each cycle, so edits take effect immediately and the loop closes.

Parameters:
CLK_HZ, 100_000_000, system clock cycles per second; prescaler terminal count is CLK_HZ-1
PRE_W, 27, prescaler width; must satisfy 2^PRE_W >= CLK_HZ

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
set_mode  in  1  high = edit mode (load n_* digits), low = run mode (count)
n_sec0  in  4  edited seconds ones digit
n_sec1  in  4  edited seconds tens digit
n_min0  in  4  edited minutes ones digit
n_min1  in  4  edited minutes tens digit
n_hrs0  in  4  edited hours ones digit
n_hrs1  in  4  edited hours tens digit
sec0, sec1, min0, min1, hrs0, hrs1  out  4 each  current time digits, registered
sec_tick  out  1  one-cycle pulse on each 1 s advance
day_wrap  out  1  one-cycle pulse coincident with sec_tick on 23:59:59 -> 00:00:00

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high.
- Reset: all digits 0 (00:00:00), prescaler 0, sec_tick 0, day_wrap 0. rst has priority over set_mode.
- Set mode (set_mode=1):
  - Each cycle, register the sanitized n_* values.
  - Prescaler is held at 0. sec_tick and day_wrap stay 0. There is no counting.
- Sanitize rules on load:
  - sec0/min0/hrs0 > 9 -> 0.
  - sec1/min1 > 5 -> 0.
  - hrs1 > 2 -> 0.
  - After those rules, if hrs1==2 and hrs0>3 -> hrs0=3.
- Run mode (set_mode=0):
  - Prescaler increments each cycle.
  - At CLK_HZ-1 it wraps to 0, and in that same cycle sec_tick=1 and the time advances by one second.
  - After set_mode falls, the first tick occurs exactly CLK_HZ cycles later.
- Carry chain, all in one cycle, with each carry gated by the tick:
  - sec0: 9->0, carries into sec1.
  - sec1: 5->0, carries into min0.
  - min0: 9->0, carries into min1.
  - min1: 5->0, carries into hours.
  - Hours: 23->00 raises day_wrap.
  - Otherwise: hrs0 9->0 with hrs1+1.
- Latency: digit outputs change on the clock edge where the prescaler wraps, or one cycle after an n_* change in set mode.
- Simultaneous events: if set_mode rises in the same cycle the prescaler would wrap, the load wins and no tick occurs.
- Reset mid-count clears the prescaler, so the next second is a full CLK_HZ cycles after rst falls.

Optional Feature:
Macro ALARM_EN.
- Defined: the block adds these ports:
  - inputs al_hrs1, al_hrs0, al_min1, al_min0 (4 bits each) and alarm_on (1 bit);
  - output alarm (1 bit, registered, reset 0).
- alarm behaviour:
  - Sets to 1 on a sec_tick that produces HH:MM:00 equal to the alarm digits while alarm_on=1.
  - Clears when alarm_on=0, when set_mode=1, or on the sec_tick that reaches HH:MM+1:00 (60 s maximum).
  - The set condition does not fire in set mode.
- Undefined: these ports and their logic are absent. Base behaviour is identical in both builds.

Decomposition:
- Shared header clock_defs.vh holds digit limit constants: SEC0_MAX=9, SEC1_MAX=5, MIN0_MAX=9, MIN1_MAX=5, HRS1_MAX=2, HRS0_MAX_AT_20=3. The time-edit stage reuses the same constants.
- One sub-module, bcd_digit:
  - Parameter MAX.
  - Inputs: clk, rst, load, load_val, inc.
  - Outputs: q, carry.
  - carry = inc && q==MAX.
  - Instantiated for sec0, sec1, min0 and min1.
- Hours use a dedicated 00-23 pair in the top module because the ones-digit limit depends on hrs1.

Test Plan (CLK_HZ=4):
- Reset: assert rst 2 cycles -> all digits 0; after release, the first sec_tick comes exactly 4 cycles later and sec0=1.
- Load 12:34:58 in set mode, drop set_mode -> 12:34:59 after 4 cycles, then 12:35:00 after 8 cycles with min carry.
- Load 23:59:59, run -> after 4 cycles 00:00:00, with sec_tick=1 and day_wrap=1 for exactly one cycle.
- Load hrs1=2, hrs0=9, min1=7, sec0=12 -> outputs hrs0=3, min1=0, sec0=0; hrs1 stays 2.
- Raise set_mode on the cycle the prescaler reaches 3 -> no tick, digits equal the n_* inputs; drop set_mode -> next tick 4 cycles later.
- ALARM_EN: alarm 07:30, alarm_on=1, load 07:29:59 -> alarm=1 at the 07:30:00 tick; it falls at 07:31:00, or immediately if alarm_on drops.
